// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: four-way round-robin arbiter. It drives a 2-to-4 decoder through address1:address0 and enable.
// Optional forced release after TIMEOUT_CYCLES is compiled in when ARB_TIMEOUT_EN is defined.
module rr_decoder_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic done,
  output logic address0,
  output logic address1,
  output logic enable,
  output logic timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] last_q, last_d;
  logic       enable_q, enable_d;
  logic [3:0] req;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       tmo_hit;
  logic       release_grant;

  assign req           = {req3, req2, req1, req0};
  assign release_grant = done | tmo_hit;

  // Walk last+4 down to last+1 so the lowest offset with a request wins; last itself is the final fallback.
  always_comb begin
    pick = last_q;
    idx  = last_q;
    for (int i = 4; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    enable_d = enable_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          addr_d   = pick;
          last_d   = pick;
          enable_d = 1'b1;
        end
      end
      GRANT: begin
        if (release_grant) begin
          if (|req) begin
            addr_d   = pick;
            last_d   = pick;
            enable_d = 1'b1;
          end else begin
            state_d  = IDLE;
            enable_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= 2'b00;
      last_q   <= 2'b11;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      enable_q <= enable_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // done on the same edge wins over the timeout, so no pulse is produced then.
  assign tmo_hit = (state_q == GRANT) && !done && (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d     = '0;
    timeout_d = tmo_hit;
    if (state_q == GRANT && !release_grant) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit            = 1'b0;
  assign timeout            = 1'b0;
`endif

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign enable   = enable_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed-vector bench for rr_decoder_arbiter; expectations queue on each edge and a negedge monitor checks them.
// Follows ARB_TIMEOUT_EN so the timeout and hold vectors match the build under test.
module tb_rr_decoder_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, req3 = 1'b0;
  logic done = 1'b0;
  logic address0, address1, enable, timeout;

  typedef struct {
    logic       en;
    logic [1:0] addr;
    logic       tmo;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_N = 2;
`else
  localparam int HOLD_N = 5;
`endif

  rr_decoder_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .done(done),
    .address0(address0), .address1(address1),
    .enable(enable), .timeout(timeout)
  );

  always #500 clk = ~clk;

  task automatic step(input logic rn, input logic [3:0] r, input logic d,
                      input logic ee, input logic [1:0] ea, input logic et, input string nm);
    exp_t e;
    reset_n = rn;
    {req3, req2, req1, req0} = r;
    done = d;
    @(posedge clk);
    #1;
    e.en = ee; e.addr = ea; e.tmo = et; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input string field, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s.%s got=%0d want=%0d", nm, field, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "enable", int'(enable), int'(e.en));
        check(e.name, "address", int'({address1, address0}), int'(e.addr));
        check(e.name, "timeout", int'(timeout), int'(e.tmo));
        $display("check %s: en=%0b addr=%0d tmo=%0b", e.name, enable, {address1, address0}, timeout);
      end
    end
  end

  initial begin : stimulus
    // Reset with all requests high, then req0 wins (pointer starts at 3).
    step(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "rst0");
    step(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "rst1");
    step(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0, "rst_rel");
    // Rotation with done every cycle.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 4'b1111, 1'b1, 1'b1, 2'(i), 1'b0, $sformatf("rot%0d", i));
    // Hold: grant req2, drop it, keep done low.
    step(1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, "hold_grant");
    for (int i = 0; i < HOLD_N; i++)
      step(1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, $sformatf("hold%0d", i));
    step(1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, "hold_rel");
    step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, "idle0");
    step(1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, "idle_done");
    // Sole requester is re-granted each cycle.
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, $sformatf("sole%0d", i));
    // Grant req0 with req3 pending and done low.
    step(1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "tmo_grant");
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0, $sformatf("tmo_hold%0d", i));
    step(1'b1, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b1, "tmo_fire");
    step(1'b1, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b0, "tmo_after");
`else
    for (int i = 0; i < 20; i++)
      step(1'b1, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0, $sformatf("persist%0d", i));
`endif
    // Reset in the middle of a grant to req3.
    step(1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, "g3");
    step(1'b0, 4'b1001, 1'b0, 1'b0, 2'd0, 1'b0, "mid_rst");
    step(1'b1, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0, "post_rst");
    step(1'b1, 4'b1001, 1'b1, 1'b1, 2'd3, 1'b0, "post_rot");
    step(1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, "final_idle");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

Four-requester round-robin arbiter that sits directly upstream of the 2-to-4 structural/behavioural decoder. It produces a registered 2-bit grant index (`address1`,`address0`) plus `enable`. The decoder expands these into one-hot grant lines `out0`..`out3`. A grant is held until the owner signals `done`, then rotates fairly among pending requesters.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16 — maximum cycles a grant may be held before forced release (used only with `ARB_TIMEOUT_EN`); legal range 2..255.

Ports:
- `clk` in 1 — single clock; all state updates on rising edge.
- `reset_n` in 1 — reset, synchronous, active-low.
- `req0`..`req3` in 1 each — request lines, level-sensitive, sampled every edge.
- `done` in 1 — grant owner releases; meaningful only while `enable`=1, ignored otherwise.
- `address0` out 1 — grant index bit 0 (LSB), to decoder `address0`.
- `address1` out 1 — grant index bit 1 (MSB), to decoder `address1`.
- `enable` out 1 — a grant is active, to decoder `enable`.
- `timeout` out 1 — one-cycle pulse on forced release.

## Operation
- All outputs are registered. Reset values: `enable`=0, `address1:address0`=00, `timeout`=0, internal last-grant pointer=3, state=IDLE, hold counter=0.
- State machine: IDLE, GRANT.
- IDLE → GRANT: on an edge with any `reqN`=1, select a requester by the round-robin rule. Load its index into `address1:address0`, set `enable`=1, and clear the hold counter.
- IDLE with no requests: stay in IDLE with `enable`=0. `address` bits hold their last value.
- Round-robin rule: search indices (last+1, last+2, last+3, last) mod 4 and take the first with `req`=1. After every grant, last := granted index.
- GRANT, `done`=0: hold `address` and `enable`. Dropping the granted `reqN` does not release the grant; only `done` (or a timeout) releases.
- GRANT, `done`=1:
  - If any `req` (sampled on the same edge) is 1, re-arbitrate on that edge. The new index loads with `enable` staying 1, so grants are back-to-back. The releasing requester has lowest priority and is re-granted only if it is the sole requester.
  - If no `req` is 1, go to IDLE and set `enable`=0.
- Address wrap: index 3 → next search starts at 0; arithmetic is 2-bit mod 4.
- `address` bits change only on edges where a new grant is issued. `address` never changes while `enable`=1 without a release.
- Reset mid-grant: `reset_n`=0 on any edge forces the reset values above. Any in-flight grant is dropped and no `timeout` pulse is produced.

## Timing
- Request-to-grant latency is 1 cycle. A `req` first high before edge k gives `enable`=1 and a valid index after edge k.
- Release latency is 1 cycle. `done` sampled at edge k changes `enable`/`address` after edge k.
- Minimum grant length is 1 cycle (`done` asserted in the first GRANT cycle is honoured).
- `enable` and `address` change together on the same edge, so the decoder sees a consistent index.
- The decoder's gate delays (NOT + AND) must settle within one `clk` period. The bench clock period must exceed 100 time units; use 1000.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter increments on every GRANT edge without `done`.
  - When the counter reaches `TIMEOUT_CYCLES`−1 with `done`=0, that edge is treated exactly as `done`=1 (re-arbitrate or go to IDLE) and `timeout`=1 is driven for the following cycle only.
  - `done` and a timeout on the same edge count as `done`: no pulse.
  - The counter clears on every new grant.
- Undefined: no counter is present, `timeout` is tied 0, and a grant is held indefinitely until `done`.

## Test plan
- Reset: hold `reset_n`=0 for 2 edges with all `req`=1 → `enable`=0, `address`=00, `timeout`=0. Release reset → after the next edge, `address`=00 and `enable`=1 (req0 wins).
- Rotation: `req0`..`req3`=1 continuously, `done`=1 every cycle → grant sequence 0,1,2,3,0 on consecutive edges with `enable` constantly 1. Decoder `out0`..`out3` are one-hot in the same order.
- Hold: grant to req2, deassert `req2`, keep `done`=0 for 5 cycles → `address`=10 and `enable`=1 throughout. Assert `done` with no requests → `enable`=0 after the next edge.
- Sole requester: only `req1`=1, `done`=1 each cycle → `address`=01 and `enable`=1 on every cycle (re-granted).
- Timeout (with `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): grant to req0 with `req3`=1 pending and `done`=0 → the grant lasts 4 cycles, then `address`=11, `enable`=1, and `timeout`=1 for exactly one cycle. Without the macro, the grant to req0 persists for 20 cycles and `timeout` stays 0.
- Reset mid-grant: assert `reset_n`=0 during a grant to req3 → after the edge, `enable`=0 and `address`=00. After release with `req3`=1 and `req0`=1, req0 is granted first (pointer reset to 3).
